// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared pipeline types and defaults for the fetch stage
package fetch_unit_pkg;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

    // Fetch addresses are always word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response bundle
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// rtl/fetch_unit_if_id_reg.sv - IF/ID pipeline register with stall, flush and bubble insertion
module if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_load,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc4;
    logic        r_valid;

    // Flush wins over stall; a bubble keeps the previous PC fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr <= NOP_WORD;
            r_pc    <= 32'h0;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP_WORD;
            r_valid <= 1'b0;
        end else if (!i_stall) begin
            if (i_load) begin
                r_instr <= i_instr;
                r_pc    <= i_pc;
                r_pc4   <= i_pc4;
                r_valid <= 1'b1;
            end else begin
                r_instr <= NOP_WORD;
                r_valid <= 1'b0;
            end
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, fetch FSM and skid buffer feeding the IF/ID register
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  next_pc,
    input  logic         stall,
    input  logic         flush,
    fetch_unit_if.master imem,
    output logic [31:0]  PC4,
    output logic [31:0]  InstrD,
    output logic [31:0]  PCD,
    output logic [31:0]  PC4D,
    output logic         validD,
    output logic         fetch_busy
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  r_buf;
    logic [31:0]  w_buf_nxt;
    logic         r_started;
    logic         w_req;
    logic         w_resp;
    logic         w_load;
    logic [31:0]  w_instr;

    // r_started keeps the request low until the first edge after reset release.
    assign w_req  = r_started && (r_state == S_FETCH);
    assign w_resp = w_req && imem.imem_ready;

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;
    assign PC4            = r_pc + 32'd4;
    assign fetch_busy     = w_req && !imem.imem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_pc      <= align_pc(RESET_PC);
            r_buf     <= 32'h0;
            r_started <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_buf     <= w_buf_nxt;
            r_started <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_buf_nxt   = r_buf;
        w_load      = 1'b0;
        w_instr     = imem.imem_rdata;
        if (flush) begin
            // Any response or buffered word this cycle is dropped.
            w_buf_nxt   = 32'h0;
            w_state_nxt = S_FETCH;
            if (!stall) begin
                w_pc_nxt = align_pc(next_pc);
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_resp) begin
                        if (!stall) begin
                            w_load   = 1'b1;
                            w_pc_nxt = align_pc(next_pc);
                        end else begin
                            w_buf_nxt   = imem.imem_rdata;
                            w_state_nxt = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        w_load      = 1'b1;
                        w_instr     = r_buf;
                        w_pc_nxt    = align_pc(next_pc);
                        w_state_nxt = S_FETCH;
                    end
                end
                default: w_state_nxt = S_FETCH;
            endcase
        end
    end

    if_id_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .i_stall (stall),
        .i_flush (flush),
        .i_load  (w_load),
        .i_instr (w_instr),
        .i_pc    (r_pc),
        .i_pc4   (PC4),
        .o_instr (InstrD),
        .o_pc    (PCD),
        .o_pc4   (PC4D),
        .o_valid (validD)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        tb_ready;
    logic        np_sel;
    logic [31:0] np_val;
    logic [31:0] next_pc;
    logic [31:0] pc4;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc4_d;
    logic        valid_d;
    logic        fetch_busy;
    int          n_checks = 0;
    int          n_errors = 0;

    fetch_unit_if imem ();

    // Memory returns addr^1 whenever the bench says it is ready.
    assign imem.imem_ready = tb_ready;
    assign imem.imem_rdata = imem.imem_addr ^ 32'h1;
    assign next_pc         = np_sel ? np_val : pc4;

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .next_pc    (next_pc),
        .stall      (stall),
        .flush      (flush),
        .imem       (imem),
        .PC4        (pc4),
        .InstrD     (instr_d),
        .PCD        (pc_d),
        .PC4D       (pc4_d),
        .validD     (valid_d),
        .fetch_busy (fetch_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0; tb_ready = 1'b1;
        np_sel = 1'b0; np_val = 32'h0;
        step(); step();
        chk("rst_req",   {31'h0, imem.imem_req}, 32'h0);
        chk("rst_addr",  imem.imem_addr, 32'h3000);
        chk("rst_instr", instr_d, 32'h0);
        chk("rst_pcd",   pc_d, 32'h0);
        chk("rst_pc4d",  pc4_d, 32'h0);
        chk("rst_valid", {31'h0, valid_d}, 32'h0);
        chk("rst_pc4",   pc4, 32'h3004);

        reset = 1'b1;
        step();
        chk("first_req",  {31'h0, imem.imem_req}, 32'h1);
        chk("first_addr", imem.imem_addr, 32'h3000);
        step();
        chk("zw0_instr", instr_d, 32'h3001);
        chk("zw0_pcd",   pc_d, 32'h3000);
        chk("zw0_pc4d",  pc4_d, 32'h3004);
        chk("zw0_valid", {31'h0, valid_d}, 32'h1);
        chk("zw0_addr",  imem.imem_addr, 32'h3004);

        tb_ready = 1'b0;
        #1;
        chk("wait0_busy", {31'h0, fetch_busy}, 32'h1);
        step();
        chk("wait1_valid", {31'h0, valid_d}, 32'h0);
        chk("wait1_instr", instr_d, 32'h0);
        chk("wait1_pcd",   pc_d, 32'h3000);
        chk("wait1_addr",  imem.imem_addr, 32'h3004);
        chk("wait1_busy",  {31'h0, fetch_busy}, 32'h1);
        step();
        chk("wait2_valid", {31'h0, valid_d}, 32'h0);
        chk("wait2_addr",  imem.imem_addr, 32'h3004);
        tb_ready = 1'b1;
        #1;
        chk("wait2_busy", {31'h0, fetch_busy}, 32'h0);
        step();
        chk("wait3_instr", instr_d, 32'h3005);
        chk("wait3_pcd",   pc_d, 32'h3004);
        chk("wait3_addr",  imem.imem_addr, 32'h3008);

        stall = 1'b1;
        step();
        chk("hold1_req",   {31'h0, imem.imem_req}, 32'h0);
        chk("hold1_instr", instr_d, 32'h3005);
        chk("hold1_addr",  imem.imem_addr, 32'h3008);
        step();
        step();
        chk("hold3_req",   {31'h0, imem.imem_req}, 32'h0);
        chk("hold3_pcd",   pc_d, 32'h3004);
        stall = 1'b0;
        step();
        chk("unhold_instr", instr_d, 32'h3009);
        chk("unhold_pcd",   pc_d, 32'h3008);
        chk("unhold_valid", {31'h0, valid_d}, 32'h1);
        chk("unhold_addr",  imem.imem_addr, 32'h300C);
        step();
        chk("next_instr", instr_d, 32'h300D);
        chk("next_pcd",   pc_d, 32'h300C);

        flush = 1'b1; np_sel = 1'b1; np_val = 32'h0000_4000;
        step();
        chk("fl_instr", instr_d, 32'h0);
        chk("fl_valid", {31'h0, valid_d}, 32'h0);
        chk("fl_pcd",   pc_d, 32'h300C);
        chk("fl_addr",  imem.imem_addr, 32'h4000);
        flush = 1'b0; np_sel = 1'b0;
        step();
        chk("fl_next_instr", instr_d, 32'h4001);
        chk("fl_next_pcd",   pc_d, 32'h4000);

        stall = 1'b1;
        step();
        chk("fs_hold_req", {31'h0, imem.imem_req}, 32'h0);
        flush = 1'b1;
        step();
        chk("fs_valid", {31'h0, valid_d}, 32'h0);
        chk("fs_addr",  imem.imem_addr, 32'h4004);
        chk("fs_req",   {31'h0, imem.imem_req}, 32'h1);
        flush = 1'b0; stall = 1'b0; np_sel = 1'b1; np_val = 32'h0000_5007;
        step();
        chk("fs_ref_instr", instr_d, 32'h4005);
        chk("fs_ref_pcd",   pc_d, 32'h4004);
        chk("align_addr",   imem.imem_addr, 32'h5004);

        np_sel = 1'b0; tb_ready = 1'b0;
        step();
        reset = 1'b0;
        #1;
        chk("mid_rst_req",   {31'h0, imem.imem_req}, 32'h0);
        chk("mid_rst_addr",  imem.imem_addr, 32'h3000);
        chk("mid_rst_instr", instr_d, 32'h0);
        chk("mid_rst_pcd",   pc_d, 32'h0);
        chk("mid_rst_pc4d",  pc4_d, 32'h0);
        chk("mid_rst_valid", {31'h0, valid_d}, 32'h0);
        chk("mid_rst_busy",  {31'h0, fetch_busy}, 32'h0);
        np_sel = 1'b1; np_val = 32'hFFFF_FFFC; tb_ready = 1'b1;
        step();
        reset = 1'b1;
        step();
        chk("rel_addr", imem.imem_addr, 32'h3000);
        step();
        chk("wrap_instr", instr_d, 32'h3001);
        chk("wrap_addr",  imem.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pc4",   pc4, 32'h0);
        np_sel = 1'b0;
        step();
        chk("wrap_instr2", instr_d, 32'hFFFF_FFFD);
        chk("wrap_pcd",    pc_d, 32'hFFFF_FFFC);
        chk("wrap_pc4d",   pc4_d, 32'h0);
        chk("wrap_addr2",  imem.imem_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
